// File: rtl/neighbor_table_writer_if.sv
`default_nettype none
// neighbor_table_writer_if: advert handshake plus data-memory port bundle.  Rev 1.0
interface neighbor_table_writer_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] nbr_id;
  logic [WORD_WIDTH-1:0] nbr_hops;
  logic [WORD_WIDTH-1:0] nbr_q;
  logic [WORD_WIDTH-1:0] data_in;
  logic [10:0]           address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] data_out;

  modport master (
    input  in_valid, nbr_id, nbr_hops, nbr_q, data_in,
    output in_ready, address, wr_en, data_out
  );

  modport slave (
    output in_valid, nbr_id, nbr_hops, nbr_q, data_in,
    input  in_ready, address, wr_en, data_out
  );
endinterface
`default_nettype wire

// File: rtl/neighbor_table_writer.sv
`default_nettype none
// neighbor_table_writer: updates/appends a neighbor entry, then rescans for max Q and tie count.  Rev 1.0
module neighbor_table_writer #(
  parameter logic [10:0] BASE_ADDR  = 11'h100,
  parameter int          MAX_NBR    = 16,
  parameter int          WORD_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   nrst,
  input  logic                   en,
  input  logic                   start,
  neighbor_table_writer_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [WORD_WIDTH-1:0]  nbr_count,
  output logic [WORD_WIDTH-1:0]  best_count
);

  localparam logic [WORD_WIDTH-1:0] MAX_CNT = WORD_WIDTH'(MAX_NBR);
  localparam logic [WORD_WIDTH-1:0] ONE     = WORD_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_RDCNT, S_SCAN, S_WRENT, S_WRCNT, S_BEST, S_WRHDR, S_DONE
  } state_t;

  state_t                state, state_n;
  logic                  ph;
  logic [WORD_WIDTH-1:0] ptr, cnt, idx;
  logic [WORD_WIDTH-1:0] id_r, hops_r, q_r;
  logic [WORD_WIDTH-1:0] bq, bc;
  logic                  ovf;

  logic                  ready_w, we_w, last_w, match_w;
  logic [10:0]           addr_w;
  logic [WORD_WIDTH-1:0] wdata_w, cnt_rd_w;

  function automatic logic [10:0] entry_addr(input logic [WORD_WIDTH-1:0] n, input logic [1:0] f);
    logic [10:0] n11;
    n11 = 11'(n);
    return BASE_ADDR + 11'd3 + (n11 * 11'd3) + {9'd0, f};
  endfunction

  assign ready_w  = (state == S_IDLE) && en && !start && nrst;
  assign cnt_rd_w = (bus.data_in > MAX_CNT) ? MAX_CNT : bus.data_in;
  assign last_w   = ((ptr + ONE) == cnt);
  assign match_w  = (bus.data_in == id_r);

  always_comb begin
    state_n = state;
    addr_w  = '0;
    we_w    = 1'b0;
    wdata_w = '0;
    case (state)
      S_IDLE: begin
        if (en && start)                 state_n = S_INIT;
        else if (bus.in_valid && ready_w) state_n = S_RDCNT;
      end
      S_INIT: begin
        addr_w = BASE_ADDR + {9'd0, ptr[1:0]};
        we_w   = 1'b1;
        if (ptr[1:0] == 2'd2) state_n = S_DONE;
      end
      S_RDCNT: begin
        addr_w = BASE_ADDR;
        if (ph) state_n = (cnt_rd_w == '0) ? S_WRENT : S_SCAN;
      end
      S_SCAN: begin
        addr_w = entry_addr(ptr, 2'd0);
        if (ph) begin
          if (match_w)     state_n = S_WRENT;
          else if (last_w) state_n = (cnt < MAX_CNT) ? S_WRENT : S_BEST;
        end
      end
      S_WRENT: begin
        addr_w = entry_addr(idx, ptr[1:0]);
        we_w   = 1'b1;
        case (ptr[1:0])
          2'd0:    wdata_w = id_r;
          2'd1:    wdata_w = hops_r;
          default: wdata_w = q_r;
        endcase
        if (ptr[1:0] == 2'd2) state_n = S_WRCNT;
      end
      // Count goes out after the entry so a half-written append is never visible.
      S_WRCNT: begin
        addr_w  = BASE_ADDR;
        we_w    = 1'b1;
        wdata_w = cnt;
        state_n = S_BEST;
      end
      S_BEST: begin
        addr_w = entry_addr(ptr, 2'd2);
        if (ph && last_w) state_n = S_WRHDR;
      end
      S_WRHDR: begin
        addr_w  = BASE_ADDR + 11'd1 + {10'd0, ptr[0]};
        we_w    = 1'b1;
        wdata_w = ptr[0] ? bq : bc;
        if (ptr[0]) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      ph         <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
      idx        <= '0;
      id_r       <= '0;
      hops_r     <= '0;
      q_r        <= '0;
      bq         <= '0;
      bc         <= '0;
      ovf        <= 1'b0;
      nbr_count  <= '0;
      best_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ph  <= 1'b0;
          ptr <= '0;
          if (bus.in_valid && ready_w) begin
            id_r   <= bus.nbr_id;
            hops_r <= bus.nbr_hops;
            q_r    <= bus.nbr_q;
          end
        end
        S_INIT: begin
          ptr <= ptr + ONE;
          if (ptr[1:0] == 2'd2) begin
            ptr        <= '0;
            nbr_count  <= '0;
            best_count <= '0;
          end
        end
        S_RDCNT: begin
          ph <= ~ph;
          if (ph) begin
            ptr <= '0;
            bq  <= '0;
            bc  <= '0;
            if (cnt_rd_w == '0) begin
              idx <= '0;
              cnt <= ONE;
            end else begin
              cnt <= cnt_rd_w;
            end
          end
        end
        S_SCAN: begin
          ph <= ~ph;
          if (ph) begin
            if (match_w) begin
              idx <= ptr;
              ptr <= '0;
            end else if (last_w) begin
              ptr <= '0;
              if (cnt < MAX_CNT) begin
                idx <= cnt;
                cnt <= cnt + ONE;
              end else begin
                ovf <= 1'b1;
              end
            end else begin
              ptr <= ptr + ONE;
            end
          end
        end
        S_WRENT: ptr <= (ptr[1:0] == 2'd2) ? '0 : ptr + ONE;
        S_WRCNT: ptr <= '0;
        S_BEST: begin
          ph <= ~ph;
          if (ph) begin
            if (bus.data_in > bq) begin
              bq <= bus.data_in;
              bc <= ONE;
            end else if (bus.data_in == bq) begin
              bc <= bc + ONE;
            end
            ptr <= last_w ? '0 : ptr + ONE;
          end
        end
        S_WRHDR: begin
          ptr <= ptr + ONE;
          if (ptr[0]) begin
            ptr        <= '0;
            nbr_count  <= cnt;
            best_count <= bc;
          end
        end
        S_DONE:  ovf <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready = ready_w;
  assign bus.address  = addr_w;
  assign bus.wr_en    = we_w && nrst;
  assign bus.data_out = wdata_w;
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign overflow     = (state == S_DONE) && ovf;

endmodule
`default_nettype wire
